// File: rtl/knn_local_buf_stager.sv
// Purpose : stage one search-space chunk into the local URAM buffer, then replay it num_passes times.
// Latency : load 1 word/cycle; first replay word valid 2 cycles after READ entry; 1 word/cycle sustained.
// Backpressure: in_ready only in LOAD; out_ready low holds the head word, at most 2 words buffered, reads stall.
//
// Ports (top):
//   clk, reset                      single clock, asynchronous active-high reset
//   start, num_words, num_passes    job request (sampled in IDLE only)
//   in_data/in_valid/in_ready       load stream from the memory reader
//   out_data/out_valid/out_ready    replay stream to the distance pipeline, out_last ends each pass
//   mem_address0/ce0/we0/d0, mem_q0 buffer port 0 (1-cycle read latency)
//   busy, done                      status; done is a one-cycle completion pulse

// Small generic FIFO (power-of-two depth). Caller never pushes when full
// and never pops when empty; occupancy is exposed for flow control.
module knn_lbs_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 2,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
endmodule

module knn_local_buf_stager #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [15:0]           num_passes,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] mem_address0,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_d0,
    input  logic [DATA_WIDTH-1:0] mem_q0,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t state_q, state_d;

    // Job parameters. last_idx_q holds N-1 so pointer wrap is a plain compare
    // at full address width (N=DEPTH gives last_idx_q = DEPTH-1).
    logic [ADDR_WIDTH-1:0] last_idx_q;
    logic [15:0]           passes_q;

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [15:0]           pass_q;
    logic                  issue_done_q;    // every read of the final pass issued
    logic                  inflight_q;      // read issued last cycle, data arrives now
    logic                  inflight_last_q; // that read was word N-1 of a pass

    logic [ADDR_WIDTH:0]   n_sat;
    logic                  load_beat;
    logic                  issue;
    logic                  rd_wrap;
    logic                  pop;
    logic                  final_pop;
    logic [2:0]            occupancy;

    logic [DATA_WIDTH:0]   fifo_head;
    logic [1:0]            fifo_count;

    assign n_sat     = (num_words > DEPTH_W) ? DEPTH_W : num_words;
    assign load_beat = (state_q == S_LOAD) && in_valid;
    assign rd_wrap   = (rd_ptr_q == last_idx_q);

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_head[DATA_WIDTH-1:0];
    assign out_last  = out_valid && fifo_head[DATA_WIDTH];

    // Words owned by the replay path = FIFO entries + the read in flight.
    // Issue only if that, less a word leaving this cycle, stays below 2:
    // the FIFO can then always accept the captured word next cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign issue     = (state_q == S_READ) && !issue_done_q &&
                       (occupancy < (3'd2 + {2'b00, pop}));

    // Once everything is issued and nothing is in flight, the last FIFO
    // entry is necessarily the final word of the final pass.
    assign final_pop = pop && issue_done_q && !inflight_q && (fifo_count == 2'd1);

    knn_lbs_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (2)
    ) u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (inflight_q),
        .push_dat_i ({inflight_last_q, mem_q0}),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .count_o    (fifo_count)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and buffer-port / handshake outputs
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        mem_ce0      = 1'b0;
        mem_we0      = 1'b0;
        mem_address0 = '0;
        mem_d0       = '0;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (n_sat == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready     = 1'b1;
                mem_ce0      = load_beat;
                mem_we0      = load_beat;
                mem_address0 = wr_ptr_q;
                mem_d0       = in_data;
                if (load_beat && (wr_ptr_q == last_idx_q)) begin
                    state_d = (passes_q == 16'd0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                mem_ce0      = issue;
                mem_address0 = rd_ptr_q;
                if (final_pop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointers, pass counter and read-pipeline tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_idx_q      <= '0;
            passes_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            pass_q          <= '0;
            issue_done_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && rd_wrap;

            if ((state_q == S_IDLE) && start) begin
                last_idx_q   <= ADDR_WIDTH'(n_sat - 1'b1);
                passes_q     <= num_passes;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                pass_q       <= '0;
                issue_done_q <= 1'b0;
            end

            if (load_beat) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            if (issue) begin
                if (rd_wrap) begin
                    rd_ptr_q <= '0;
                    pass_q   <= pass_q + 16'd1;
                    if (pass_q == (passes_q - 16'd1)) begin
                        issue_done_q <= 1'b1;
                    end
                end else begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end
endmodule
